// File: rtl/mac_pkg.sv
// Shared sizing helpers for the pipelined dot-product unit.
package mac_pkg;

  // Full-precision width of the tree sum: one product plus log2(vlen) carry bits.
  function automatic int sumw(input int aw, input int bw, input int vlen);
    return aw + bw + $clog2(vlen);
  endfunction

  // Number of registered adder levels; a single-lane unit still gets one stage.
  function automatic int levels(input int vlen);
    return (vlen <= 1) ? 1 : $clog2(vlen);
  endfunction

  // Number of live values after lvl pairwise reductions (odd counts pad a zero).
  function automatic int stage_count(input int vlen, input int lvl);
    int c;
    c = vlen;
    for (int i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_adder_stage.sv
// One registered level of the adder tree: N inputs reduce to ceil(N/2) sums.
// An odd trailing input is paired with zero. Registers hold while i_en is low.
module mac_adder_stage
  import mac_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 34
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic                         i_en,
  input  logic [N_IN*W-1:0]            i_data,
  output logic [((N_IN+1)/2)*W-1:0]    o_data
);

  localparam int N_OUT = (N_IN + 1) / 2;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_pair
      logic [W-1:0] w_lhs;
      logic [W-1:0] w_rhs;
      logic [W-1:0] r_sum;

      assign w_lhs = i_data[2*gi*W +: W];

      if (2*gi + 1 < N_IN) begin : g_full
        assign w_rhs = i_data[(2*gi+1)*W +: W];
      end else begin : g_pad
        assign w_rhs = '0;
      end

      // Pairwise sum, loaded only when the valid bit entering this level is set.
      always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
          r_sum <= '0;
        end else if (i_en) begin
          r_sum <= w_lhs + w_rhs;
        end
      end

      assign o_data[gi*W +: W] = r_sum;
    end
  endgenerate

endmodule

// File: rtl/mac.sv
// Pipelined signed dot product: out = (sum a[i]*b[i]) >>> OUTPUT_SCALE,
// wrapped to OUTPUT_WIDTH. Products are combinational, the binary adder tree
// has LEVELS registered stages, and the last stage register is out itself
// (shift and truncation are pure wiring on that register).
module mac
  import mac_pkg::*;
#(
  parameter int A_WIDTH      = 16,
  parameter int B_WIDTH      = 16,
  parameter int OUTPUT_WIDTH = 34,
  parameter int OUTPUT_SCALE = 0,
  parameter int VLEN         = 4
) (
  input  logic                    clk,
  input  logic                    arst_n_in,
  input  logic                    input_valid,
  input  logic [A_WIDTH-1:0]      a [0:VLEN-1],
  input  logic [B_WIDTH-1:0]      b [0:VLEN-1],
  output logic [OUTPUT_WIDTH-1:0] out
);

  localparam int SUMW   = sumw(A_WIDTH, B_WIDTH, VLEN);
  localparam int LEVELS = levels(VLEN);
  localparam int PW     = A_WIDTH + B_WIDTH;
  localparam int EXTW   = (OUTPUT_WIDTH > SUMW) ? OUTPUT_WIDTH : SUMW;

  logic [VLEN*SUMW-1:0] w_prod_flat;

  genvar gi;
  generate
    // Signed products, sign-extended to the full tree width.
    for (gi = 0; gi < VLEN; gi++) begin : g_mul
      logic signed [PW-1:0] w_a_ext;
      logic signed [PW-1:0] w_b_ext;
      logic signed [PW-1:0] w_prod;

      assign w_a_ext = PW'($signed(a[gi]));
      assign w_b_ext = PW'($signed(b[gi]));
      assign w_prod  = w_a_ext * w_b_ext;
      assign w_prod_flat[gi*SUMW +: SUMW] = SUMW'(w_prod);
    end

    // Adder tree levels; each level forwards a valid bit to gate the next.
    for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
      localparam int N_IN  = stage_count(VLEN, gi);
      localparam int N_OUT = stage_count(VLEN, gi + 1);

      logic [N_IN*SUMW-1:0]  w_in;
      logic                  w_in_vld;
      logic [N_OUT*SUMW-1:0] w_out;

      if (gi == 0) begin : g_first
        assign w_in     = w_prod_flat;
        assign w_in_vld = input_valid;
      end else begin : g_next
        assign w_in     = g_lvl[gi-1].w_out;
        assign w_in_vld = g_lvl[gi-1].g_vld.r_vld;
      end

      // The last level has no successor, so its valid bit is not kept.
      if (gi < LEVELS - 1) begin : g_vld
        logic r_vld;

        // Valid shift register stage travelling alongside the data.
        always_ff @(posedge clk or negedge arst_n_in) begin
          if (!arst_n_in) begin
            r_vld <= 1'b0;
          end else begin
            r_vld <= w_in_vld;
          end
        end
      end

      mac_adder_stage #(
        .N_IN (N_IN),
        .W    (SUMW)
      ) u_stage (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .i_en      (w_in_vld),
        .i_data    (w_in),
        .o_data    (w_out)
      );
    end
  endgenerate

  logic [SUMW-1:0]        w_final;
  logic signed [EXTW-1:0] w_ext;
  logic signed [EXTW-1:0] w_scaled;

  assign w_final  = g_lvl[LEVELS-1].w_out;
  assign w_ext    = EXTW'($signed(w_final));
  assign w_scaled = w_ext >>> OUTPUT_SCALE;
  assign out      = w_scaled[OUTPUT_WIDTH-1:0];

endmodule

// File: tb/tb_mac.sv
// Directed and streaming checks for the pipelined dot-product unit.
// Two instances share stimulus: scale 0 (dut) and scale 2 (dut_s2).
module tb_mac;

  logic        clk;
  logic        arst_n_in;
  logic        input_valid;
  logic [15:0] a [0:3];
  logic [15:0] b [0:3];
  logic [33:0] out;
  logic [33:0] out_s2;

  int checks   = 0;
  int failures = 0;

  mac #(
    .A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(34), .OUTPUT_SCALE(0), .VLEN(4)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .input_valid(input_valid),
    .a(a), .b(b), .out(out)
  );

  mac #(
    .A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(34), .OUTPUT_SCALE(2), .VLEN(4)
  ) dut_s2 (
    .clk(clk), .arst_n_in(arst_n_in), .input_valid(input_valid),
    .a(a), .b(b), .out(out_s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive4(input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3);
    a[0] = 16'(a0); a[1] = 16'(a1); a[2] = 16'(a2); a[3] = 16'(a3);
    b[0] = 16'(b0); b[1] = 16'(b1); b[2] = 16'(b2); b[3] = 16'(b3);
  endtask

  task automatic test_reset();
    drive4(7, 7, 7, 7, 3, 3, 3, 3);
    input_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (out !== 34'd0) begin
        failures++;
        $display("FAIL reset_hold out=%0d expected=0", $signed(out));
      end
      checks++;
      if (out_s2 !== 34'd0) begin
        failures++;
        $display("FAIL reset_hold_s2 out=%0d expected=0", $signed(out_s2));
      end
    end
    arst_n_in   = 1'b1;
    input_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out !== 34'd0) begin
        failures++;
        $display("FAIL reset_idle out=%0d expected=0", $signed(out));
      end
    end
    $display("reset: out=%0d", $signed(out));
  endtask

  task automatic test_simple();
    drive4(1, 2, 3, 4, 5, 6, 7, 8);
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out !== 34'd70) begin
      failures++;
      $display("FAIL simple_dot out=%0d expected=70", $signed(out));
    end
    checks++;
    if (out_s2 !== 34'd17) begin
      failures++;
      $display("FAIL simple_dot_s2 out=%0d expected=17", $signed(out_s2));
    end
    $display("vec {1,2,3,4}.{5,6,7,8}: out=%0d out_s2=%0d", $signed(out), $signed(out_s2));
  endtask

  task automatic test_sign();
    drive4(-1, -1, -1, -1, 1, 1, 1, 1);
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out !== 34'h3_FFFF_FFFC) begin
      failures++;
      $display("FAIL sign_dot out=%h expected=3fffffffc", out);
    end
    checks++;
    if (out_s2 !== 34'h3_FFFF_FFFF) begin
      failures++;
      $display("FAIL sign_dot_s2 out=%0d expected=-1", $signed(out_s2));
    end
    $display("vec {-1x4}.{1x4}: out=%0d out_s2=%0d", $signed(out), $signed(out_s2));
  endtask

  task automatic test_extreme();
    longint e;
    logic [33:0] e34;
    drive4(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    input_valid = 1'b1;
    @(negedge clk);
    drive4(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767);
    @(negedge clk);
    input_valid = 1'b0;
    checks++;
    if (out !== 34'h1_0000_0000) begin
      failures++;
      $display("FAIL extreme_pos out=%h expected=100000000", out);
    end
    checks++;
    if (out_s2 !== 34'h0_4000_0000) begin
      failures++;
      $display("FAIL extreme_pos_s2 out=%h expected=040000000", out_s2);
    end
    $display("vec {-32768}.{-32768}: out=%0d", $signed(out));
    @(negedge clk);
    e   = -64'sd4294836224;
    e34 = e[33:0];
    checks++;
    if (out !== e34) begin
      failures++;
      $display("FAIL extreme_neg out=%0d expected=%0d", $signed(out), e);
    end
    e   = -64'sd1073709056;
    e34 = e[33:0];
    checks++;
    if (out_s2 !== e34) begin
      failures++;
      $display("FAIL extreme_neg_s2 out=%0d expected=%0d", $signed(out_s2), e);
    end
    $display("vec {-32768}.{32767}: out=%0d out_s2=%0d", $signed(out), $signed(out_s2));
  endtask

  task automatic test_back_to_back();
    longint gold [0:99];
    longint s;
    logic [33:0] e34;
    logic [33:0] e34_s2;
    for (int n = 0; n < 102; n++) begin
      if (n >= 2) begin
        s      = gold[n-2];
        e34    = s[33:0];
        s      = gold[n-2] >>> 2;
        e34_s2 = s[33:0];
        checks++;
        if (out !== e34) begin
          failures++;
          $display("FAIL stream[%0d] out=%0d expected=%0d", n - 2, $signed(out), gold[n-2]);
        end
        checks++;
        if (out_s2 !== e34_s2) begin
          failures++;
          $display("FAIL stream_s2[%0d] out=%0d expected=%0d", n - 2, $signed(out_s2), s);
        end
        $display("stream[%0d]: out=%0d out_s2=%0d", n - 2, $signed(out), $signed(out_s2));
      end
      if (n < 100) begin
        s = 0;
        for (int i = 0; i < 4; i++) begin
          a[i] = 16'($urandom);
          b[i] = 16'($urandom);
          s += longint'($signed(a[i])) * longint'($signed(b[i]));
        end
        gold[n]     = s;
        input_valid = 1'b1;
      end else begin
        input_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_valid_hold();
    drive4(1, 2, 3, 4, 5, 6, 7, 8);
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive4(100 + c, -5, 9, 1, 3, 3, -8, 2);
      @(negedge clk);
      checks++;
      if (out !== 34'd70) begin
        failures++;
        $display("FAIL valid_hold[%0d] out=%0d expected=70", c, $signed(out));
      end
      checks++;
      if (out_s2 !== 34'd17) begin
        failures++;
        $display("FAIL valid_hold_s2[%0d] out=%0d expected=17", c, $signed(out_s2));
      end
    end
    $display("hold: out=%0d out_s2=%0d", $signed(out), $signed(out_s2));
  endtask

  task automatic test_reset_in_flight();
    drive4(2, 2, 2, 2, 3, 3, 3, 3);
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    arst_n_in   = 1'b0;
    #1;
    checks++;
    if (out !== 34'd0) begin
      failures++;
      $display("FAIL async_reset out=%0d expected=0", $signed(out));
    end
    @(negedge clk);
    arst_n_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out !== 34'd0) begin
        failures++;
        $display("FAIL in_flight_discard[%0d] out=%0d expected=0", c, $signed(out));
      end
    end
    $display("reset in flight: out=%0d", $signed(out));
  endtask

  initial begin
    arst_n_in   = 1'b0;
    input_valid = 1'b0;
    drive4(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_simple();
    test_sign();
    test_extreme();
    test_back_to_back();
    test_valid_hold();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
